// File: rtl/parking_gate_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_arbiter_if
// Description : Lane request / passage event / gate command bundle shared by
//               the parking gate arbiter and whatever drives its sensors.
// Revision    : 1.0 - initial release
// ============================================================================
interface parking_gate_arbiter_if;
    logic       tick_ms;
    logic       req_in;
    logic       req_out;
    logic       ev_s;
    logic       ev_r;
    logic       gate_open;
    logic       lane_in;
    logic       lane_out;
    logic [2:0] occupancy;
    logic       full;
    logic       timeout_err;

    // Sensor / timing side: drives requests and passage events
    modport master (
        output tick_ms, req_in, req_out, ev_s, ev_r,
        input  gate_open, lane_in, lane_out, occupancy, full, timeout_err
    );

    // Arbiter side
    modport slave (
        input  tick_ms, req_in, req_out, ev_s, ev_r,
        output gate_open, lane_in, lane_out, occupancy, full, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : parking_gate_arbiter
// Description : Single-barrier parking gate shared by an entry and an exit
//               lane. Grants one lane at a time, tracks car occupancy, closes
//               the window on passage or timeout, then holds a closed guard.
//               Optional macro PARKING_FAIR_RR_EN: round-robin tie breaking
//               (otherwise ties always go to the exit lane).
// Revision    : 1.0 - initial release
// ============================================================================
module parking_gate_arbiter #(
    parameter int CAPACITY = 7,
    parameter int OPEN_MS  = 3000,
    parameter int GUARD_MS = 500
) (
    input  logic                   clk,
    input  logic                   rst_n,
    parking_gate_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        GRANT_IN  = 2'd1,
        GRANT_OUT = 2'd2,
        GUARD     = 2'd3
    } state_t;

    localparam logic [2:0]  c_capacity   = 3'(CAPACITY);
    localparam logic [11:0] c_open_last  = 12'(OPEN_MS - 1);
    localparam logic [11:0] c_guard_last = 12'(GUARD_MS - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [11:0] r_timer;
    logic [11:0] w_timer_next;
    logic [2:0]  r_occupancy;
    logic [2:0]  w_occupancy_next;
    logic        r_gate_open;
    logic        r_lane_in;
    logic        r_lane_out;
    logic        r_timeout_err;
    logic        w_timeout_err;
    logic        w_full;
    logic        w_in_elig;
    logic        w_out_elig;
    logic        w_tie_pick_out;
    logic        w_window_end;

    assign w_full       = (r_occupancy == c_capacity);
    assign w_in_elig    = bus.req_in & ~w_full;
    assign w_out_elig   = bus.req_out & (r_occupancy != 3'd0);
    // The tick that would bring the window timer up to OPEN_MS
    assign w_window_end = bus.tick_ms & (r_timer == c_open_last);

`ifdef PARKING_FAIR_RR_EN
    logic r_prefer_out;
    logic w_prefer_out_next;

    // Pointer points at the lane that did not get the most recent grant
    always_comb begin
        w_prefer_out_next = r_prefer_out;
        if (r_state == IDLE && w_next_state == GRANT_IN) begin
            w_prefer_out_next = 1'b1;
        end else if (r_state == IDLE && w_next_state == GRANT_OUT) begin
            w_prefer_out_next = 1'b0;
        end
    end

    // Round-robin pointer register, exit preferred out of reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prefer_out <= 1'b1;
        end else begin
            r_prefer_out <= w_prefer_out_next;
        end
    end

    assign w_tie_pick_out = r_prefer_out;
`else
    assign w_tie_pick_out = 1'b1;
`endif

    // Next-state, window/guard timer, occupancy and timeout decode
    always_comb begin
        w_next_state     = r_state;
        w_timer_next     = r_timer;
        w_occupancy_next = r_occupancy;
        w_timeout_err    = 1'b0;
        case (r_state)
            IDLE: begin
                w_timer_next = 12'd0;
                if (w_in_elig && w_out_elig) begin
                    w_next_state = w_tie_pick_out ? GRANT_OUT : GRANT_IN;
                end else if (w_in_elig) begin
                    w_next_state = GRANT_IN;
                end else if (w_out_elig) begin
                    w_next_state = GRANT_OUT;
                end
            end
            GRANT_IN: begin
                // A passage on the expiry tick still counts as a passage
                if (bus.ev_s) begin
                    w_occupancy_next = (r_occupancy == c_capacity) ? r_occupancy
                                                                   : r_occupancy + 3'd1;
                    w_next_state     = GUARD;
                    w_timer_next     = 12'd0;
                end else if (w_window_end) begin
                    w_timeout_err = 1'b1;
                    w_next_state  = GUARD;
                    w_timer_next  = 12'd0;
                end else if (bus.tick_ms) begin
                    w_timer_next = r_timer + 12'd1;
                end
            end
            GRANT_OUT: begin
                if (bus.ev_r) begin
                    w_occupancy_next = (r_occupancy == 3'd0) ? r_occupancy
                                                             : r_occupancy - 3'd1;
                    w_next_state     = GUARD;
                    w_timer_next     = 12'd0;
                end else if (w_window_end) begin
                    w_timeout_err = 1'b1;
                    w_next_state  = GUARD;
                    w_timer_next  = 12'd0;
                end else if (bus.tick_ms) begin
                    w_timer_next = r_timer + 12'd1;
                end
            end
            GUARD: begin
                if (bus.tick_ms) begin
                    if (r_timer == c_guard_last) begin
                        w_next_state = IDLE;
                        w_timer_next = 12'd0;
                    end else begin
                        w_timer_next = r_timer + 12'd1;
                    end
                end
            end
            default: begin
                w_next_state = IDLE;
                w_timer_next = 12'd0;
            end
        endcase
    end

    // State, timer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_timer     <= 12'd0;
            r_occupancy <= 3'd0;
        end else begin
            r_state     <= w_next_state;
            r_timer     <= w_timer_next;
            r_occupancy <= w_occupancy_next;
        end
    end

    // Outputs registered from the next state so they track the state exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gate_open   <= 1'b0;
            r_lane_in     <= 1'b0;
            r_lane_out    <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_gate_open   <= (w_next_state == GRANT_IN) || (w_next_state == GRANT_OUT);
            r_lane_in     <= (w_next_state == GRANT_IN);
            r_lane_out    <= (w_next_state == GRANT_OUT);
            r_timeout_err <= w_timeout_err;
        end
    end

    assign bus.gate_open   = r_gate_open;
    assign bus.lane_in     = r_lane_in;
    assign bus.lane_out    = r_lane_out;
    assign bus.occupancy   = r_occupancy;
    assign bus.full        = w_full;
    assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_parking_gate_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_parking_gate_arbiter
// Description : Self-checking bench for parking_gate_arbiter. Expected grants
//               and timeouts are queued when stimulus is applied and matched
//               against what the gate actually does.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_parking_gate_arbiter;

    localparam int CAPACITY     = 7;
    localparam int OPEN_MS      = 3000;
    localparam int GUARD_MS     = 500;
    localparam int GUARD_BUDGET = 2 * GUARD_MS + 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    parking_gate_arbiter_if bus();

    parking_gate_arbiter #(
        .CAPACITY (CAPACITY),
        .OPEN_MS  (OPEN_MS),
        .GUARD_MS (GUARD_MS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_q[$];          // 1 = entry grant, 2 = exit grant, 3 = timeout
    int   exp_occ = 0;
    bit   exp_prefer_out = 1'b1;
    logic prev_gate = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_pop(input int obs);
        int e;
        if (exp_q.size() == 0) begin
            check("sb_unexpected", obs, 0);
        end else begin
            e = exp_q.pop_front();
            check("sb_event", obs, e);
        end
    endtask

    // Reference tie-break: exit unless round-robin says it is entry's turn
    function automatic int tie_winner();
`ifdef PARKING_FAIR_RR_EN
        return exp_prefer_out ? 2 : 1;
`else
        return 2;
`endif
    endfunction

    task automatic expect_grant(input int lane);
        exp_q.push_back(lane);
        exp_prefer_out = (lane == 1);
    endtask

    // Monitor: every gate opening and timeout pulse is matched to the queue
    always @(negedge clk) begin
        if (bus.gate_open && !prev_gate)
            sb_pop(bus.lane_in ? 1 : (bus.lane_out ? 2 : 0));
        if (bus.timeout_err)
            sb_pop(3);
        prev_gate <= bus.gate_open;
    end

    // 1 kHz strobe model: one tick every other clock
    initial begin
        bus.tick_ms = 1'b0;
        forever begin
            @(negedge clk);
            bus.tick_ms = ~bus.tick_ms;
        end
    end

    task automatic wait_gate(input logic val, input int budget, input string tag);
        int k = 0;
        while (bus.gate_open !== val && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, bus.gate_open, val);
    endtask

    task automatic pulse_ev(input bit entry);
        if (entry) bus.ev_s = 1'b1;
        else       bus.ev_r = 1'b1;
        @(negedge clk);
        bus.ev_s = 1'b0;
        bus.ev_r = 1'b0;
    endtask

    task automatic bump_occ(input int lane);
        if (lane == 1 && exp_occ < CAPACITY) exp_occ++;
        if (lane == 2 && exp_occ > 0)        exp_occ--;
    endtask

    task automatic do_pass(input int lane, input string tag);
        if (lane == 1) bus.req_in  = 1'b1;
        else           bus.req_out = 1'b1;
        expect_grant(lane);
        wait_gate(1'b1, 20, {tag, "_open"});
        bus.req_in  = 1'b0;
        bus.req_out = 1'b0;
        repeat (3) @(negedge clk);
        pulse_ev(lane == 1);
        bump_occ(lane);
        check({tag, "_occ"}, bus.occupancy, exp_occ);
        check({tag, "_closed"}, bus.gate_open, 0);
        repeat (GUARD_BUDGET) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int  n;
        int  cnt;
        bit  started;
        bit  done;
        int  w;
        bus.req_in  = 1'b0;
        bus.req_out = 1'b0;
        bus.ev_s    = 1'b0;
        bus.ev_r    = 1'b0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_gate", bus.gate_open, 0);
        check("rst_lane_in", bus.lane_in, 0);
        check("rst_lane_out", bus.lane_out, 0);
        check("rst_occ", bus.occupancy, 0);
        check("rst_full", bus.full, 0);
        check("rst_timeout", bus.timeout_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic entry with passage 10 ticks later
        bus.req_in = 1'b1;
        expect_grant(1);
        repeat (2) @(negedge clk);
        check("in_gate_2nd_clk", bus.gate_open, 1);
        check("in_lane_in", bus.lane_in, 1);
        check("in_lane_out", bus.lane_out, 0);
        bus.req_in = 1'b0;
        repeat (20) @(negedge clk);
        check("in_occ_before_ev", bus.occupancy, 0);
        pulse_ev(1'b1);
        exp_occ = 1;
        check("in_occ_after_ev", bus.occupancy, exp_occ);
        check("in_gate_closed", bus.gate_open, 0);

        // Guard length: request held through the guard, measure the reopen
        bus.req_in = 1'b1;
        expect_grant(1);
        n = 0;
        while (!bus.gate_open && n < GUARD_BUDGET) begin
            @(negedge clk);
            n++;
        end
        check("guard_len_ok", (n >= 2 * GUARD_MS - 4 && n <= 2 * GUARD_MS + 4), 1);
        bus.req_in = 1'b0;
        repeat (3) @(negedge clk);
        pulse_ev(1'b1);
        exp_occ = 2;
        check("guard_occ", bus.occupancy, exp_occ);
        repeat (GUARD_BUDGET) @(negedge clk);

        // Window timeout with no passage
        bus.req_in = 1'b1;
        expect_grant(1);
        wait_gate(1'b1, 20, "to_open");
        bus.req_in = 1'b0;
        exp_q.push_back(3);
        n = 0;
        while (!bus.timeout_err && n < 2 * OPEN_MS + 20) begin
            @(negedge clk);
            n++;
        end
        check("to_pulse", bus.timeout_err, 1);
        check("to_len_ok", (n >= 2 * OPEN_MS - 4 && n <= 2 * OPEN_MS + 4), 1);
        check("to_occ", bus.occupancy, exp_occ);
        check("to_gate", bus.gate_open, 0);
        check("to_lane_in", bus.lane_in, 0);
        @(negedge clk);
        check("to_single", bus.timeout_err, 0);
        repeat (GUARD_BUDGET) @(negedge clk);

        // Exit: stray ev_s ignored, ev_r on the expiry tick wins
        bus.req_out = 1'b1;
        expect_grant(2);
        started = 1'b0;
        done    = 1'b0;
        cnt     = 0;
        for (int c = 0; c < 2 * OPEN_MS + 100 && !done; c++) begin
            @(negedge clk);
            #1;
            bus.ev_s = 1'b0;
            bus.ev_r = 1'b0;
            if (!started && bus.gate_open) begin
                started     = 1'b1;
                bus.req_out = 1'b0;
            end
            if (started && bus.tick_ms) begin
                cnt++;
                if (cnt == 5) bus.ev_s = 1'b1;
                if (cnt == 10) check("co_evs_ignored", bus.occupancy, exp_occ);
                if (cnt == OPEN_MS) begin
                    bus.ev_r = 1'b1;
                    done     = 1'b1;
                end
            end
        end
        check("co_reached", done, 1);
        @(negedge clk);
        #1;
        bus.ev_r = 1'b0;
        bump_occ(2);
        check("co_occ", bus.occupancy, exp_occ);
        check("co_no_timeout", bus.timeout_err, 0);
        check("co_gate", bus.gate_open, 0);
        repeat (GUARD_BUDGET) @(negedge clk);

        // Asynchronous reset in the middle of an entry grant
        bus.req_in = 1'b1;
        expect_grant(1);
        wait_gate(1'b1, 20, "ar_open");
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_gate", bus.gate_open, 0);
        check("ar_lane_in", bus.lane_in, 0);
        check("ar_occ", bus.occupancy, 0);
        exp_occ        = 0;
        exp_prefer_out = 1'b1;
        expect_grant(1);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        check("ar_release_no_grant", bus.gate_open, 0);
        wait_gate(1'b1, 20, "ar_regrant");
        bus.req_in = 1'b0;
        repeat (3) @(negedge clk);
        pulse_ev(1'b1);
        bump_occ(1);
        check("ar_occ_after", bus.occupancy, exp_occ);
        repeat (GUARD_BUDGET) @(negedge clk);

        // Bring occupancy to 3, then hold both requests over three grants
        do_pass(1, "pre3_a");
        do_pass(1, "pre3_b");
        bus.req_in  = 1'b1;
        bus.req_out = 1'b1;
        for (int g = 0; g < 3; g++) begin
            w = tie_winner();
            expect_grant(w);
            wait_gate(1'b1, GUARD_BUDGET, "tie_open");
            check("tie_lane_out", bus.lane_out, (w == 2));
            repeat (3) @(negedge clk);
            if (g == 2) begin
                bus.req_in  = 1'b0;
                bus.req_out = 1'b0;
            end
            pulse_ev(w == 1);
            bump_occ(w);
            check("tie_occ", bus.occupancy, exp_occ);
        end
        repeat (GUARD_BUDGET) @(negedge clk);

        // Full lot: entry refused, exit frees a slot
        while (exp_occ < CAPACITY) do_pass(1, "fill");
        check("full_occ", bus.occupancy, CAPACITY);
        check("full_flag", bus.full, 1);
        bus.req_in = 1'b1;
        repeat (60) @(negedge clk);
        check("full_no_grant", bus.gate_open, 0);
        check("full_still", bus.full, 1);
        bus.req_out = 1'b1;
        expect_grant(2);
        wait_gate(1'b1, 20, "full_out_open");
        check("full_out_lane", bus.lane_out, 1);
        bus.req_out = 1'b0;
        repeat (3) @(negedge clk);
        pulse_ev(1'b0);
        bus.req_in = 1'b0;
        bump_occ(2);
        check("full_out_occ", bus.occupancy, exp_occ);
        check("full_cleared", bus.full, 0);
        repeat (GUARD_BUDGET) @(negedge clk);

        check("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
